hrange_consumer: RTL and testbench

Caller-side counterpart to the generated range generators (`hrange`-style producers). On a host `_start` it latches `(base, limit, step)`, launches a child generator through the `gen_*` port group, and consumes every `(_0, _1)` pair the child yields. Consumption is under `_ready`/`_valid` flow control with optional programmable back-pressure. When the child finishes, the block returns the sum of all yielded `_0` values and the yield count to the host over the same `_start`/`_ready`/`_valid`/`_done` protocol the generators use. It serves as the reference consumer for co-simulating generated producers and as the pattern for hardware callers of generator modules.

---
 rtl/hrange_consumer_if.sv | 22 ++
 rtl/hrange_consumer.sv | 144 ++++++++++++++
 tb/tb_hrange_consumer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hrange_consumer_if.sv
// rtl/hrange_consumer_if.sv - call/yield handshake bundle used for both the host port and the child generator port
interface hrange_consumer_if;
    logic               _start;
    logic signed [31:0] base;
    logic signed [31:0] limit;
    logic signed [31:0] step;
    logic               _ready;
    logic               _valid;
    logic               _done;
    logic signed [31:0] _0;
    logic        [31:0] _1;

    modport master (
        output _start, base, limit, step, _ready,
        input  _valid, _done, _0, _1
    );

    modport slave (
        input  _start, base, limit, step, _ready,
        output _valid, _done, _0, _1
    );
endinterface

// File: rtl/hrange_consumer.sv
// rtl/hrange_consumer.sv - launches a range generator child, sums its _0 yields and reports sum/count to the host
module hrange_consumer #(
    parameter int unsigned STALL_EVERY = 0
) (
    input  logic              _clock,
    input  logic              _reset,
    hrange_consumer_if.slave  host,
    hrange_consumer_if.master gen
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        CONSUME,
        REPORT
    } state_t;

    localparam logic [31:0] STALL_LIMIT = STALL_EVERY;

    state_t             state, state_n;
    logic signed [31:0] sum_q, sum_n;
    logic        [31:0] count_q, count_n;
    logic        [31:0] stall_q, stall_n;
    logic signed [31:0] res0_q, res0_n;
    logic        [31:0] res1_q, res1_n;
    logic signed [31:0] base_q, base_n;
    logic signed [31:0] limit_q, limit_n;
    logic signed [31:0] step_q, step_n;
    logic               start_q, start_n;
    logic               ready_q, ready_n;
    logic               valid_q, valid_n;
    logic               transfer;
    bit                 no_parity_check = 1'b0;

    // ready_q is the registered gen__ready, so a handshake is judged on what the child actually saw
    assign transfer = (state == CONSUME) && gen._valid && ready_q;

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state   <= IDLE;
            sum_q   <= '0;
            count_q <= '0;
            stall_q <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            base_q  <= '0;
            limit_q <= '0;
            step_q  <= '0;
            start_q <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            sum_q   <= sum_n;
            count_q <= count_n;
            stall_q <= stall_n;
            res0_q  <= res0_n;
            res1_q  <= res1_n;
            base_q  <= base_n;
            limit_q <= limit_n;
            step_q  <= step_n;
            start_q <= start_n;
            ready_q <= ready_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        sum_n   = sum_q;
        count_n = count_q;
        stall_n = stall_q;
        res0_n  = res0_q;
        res1_n  = res1_q;
        base_n  = base_q;
        limit_n = limit_q;
        step_n  = step_q;
        start_n = 1'b0;
        ready_n = 1'b0;
        valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (host._start) begin
                    base_n  = host.base;
                    limit_n = host.limit;
                    step_n  = host.step;
                    sum_n   = '0;
                    count_n = '0;
                    stall_n = '0;
                    start_n = 1'b1;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: begin
                ready_n = 1'b1;
                state_n = CONSUME;
            end
            CONSUME: begin
                ready_n = 1'b1;
                if (transfer) begin
                    sum_n   = sum_q + gen._0;
                    count_n = count_q + 32'd1;
                    stall_n = stall_q + 32'd1;
                    if ((STALL_EVERY != 0) && (stall_n == STALL_LIMIT)) begin
                        stall_n = '0;
                        ready_n = 1'b0;
                    end
                end
                // done seen while ready is low (stall cycle) is left for the next ready cycle
                if (gen._done && ready_q) begin
                    ready_n = 1'b0;
                    valid_n = 1'b1;
                    res0_n  = sum_n;
                    res1_n  = count_n;
                    state_n = REPORT;
                end
            end
            REPORT: begin
                if (host._ready) begin
                    state_n = IDLE;
                end else begin
                    valid_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign host._valid = valid_q;
    assign host._done  = valid_q;
    assign host._0     = res0_q;
    assign host._1     = res1_q;
    assign gen._start  = start_q;
    assign gen.base    = base_q;
    assign gen.limit   = limit_q;
    assign gen.step    = step_q;
    assign gen._ready  = ready_q;

    // producers that yield (i, i) are checked for agreement
    parity_check: assert property (@(posedge _clock)
        disable iff (_reset || no_parity_check)
        transfer |-> (gen._1 == gen._0));

endmodule

// File: tb/tb_hrange_consumer.sv
// tb/tb_hrange_consumer.sv - randomized self-checking bench for hrange_consumer with a behavioural range child
module tb_hrange_consumer;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         h_start, h_ready;
    logic signed [31:0] h_base, h_limit, h_step;
    logic [1:0]         o_valid, o_done, o_gstart, o_gready, o_gvalid, o_gdone;
    logic signed [31:0] o_0 [2];
    logic        [31:0] o_1 [2];
    logic signed [31:0] o_gbase [2];
    logic signed [31:0] o_glimit [2];
    logic signed [31:0] o_gstep [2];
    bit                 gap_en, dwl;
    int                 passed = 0;
    int                 total = 0;
    bit                 tr_ready [$];
    bit                 tr_valid [$];
    bit                 tr_done [$];
    bit                 tr_gs [$];

    always #5 clk = ~clk;

    // lane 0 runs without stalls, lane 1 stalls after every 2nd accepted yield
    for (genvar g = 0; g < 2; g++) begin : lane
        hrange_consumer_if host_if ();
        hrange_consumer_if gen_if ();
        int   cur, lim, stp;
        logic active, gap;

        hrange_consumer #(.STALL_EVERY(g * 2)) u_dut (
            ._clock (clk),
            ._reset (rst),
            .host   (host_if),
            .gen    (gen_if)
        );

        assign host_if._start = h_start[g];
        assign host_if.base   = h_base;
        assign host_if.limit  = h_limit;
        assign host_if.step   = h_step;
        assign host_if._ready = h_ready[g];
        assign o_valid[g]     = host_if._valid;
        assign o_done[g]      = host_if._done;
        assign o_0[g]         = host_if._0;
        assign o_1[g]         = host_if._1;
        assign o_gstart[g]    = gen_if._start;
        assign o_gready[g]    = gen_if._ready;
        assign o_gvalid[g]    = gen_if._valid;
        assign o_gdone[g]     = gen_if._done;
        assign o_gbase[g]     = gen_if.base;
        assign o_glimit[g]    = gen_if.limit;
        assign o_gstep[g]     = gen_if.step;

        assign gen_if._valid = active && !gap && (cur < lim);
        assign gen_if._done  = active && ((cur >= lim) || (dwl && !gap && (cur + stp >= lim)));
        assign gen_if._0     = cur;
        assign gen_if._1     = cur;

        always @(posedge clk) begin
            if (rst) begin
                active <= 1'b0;
                gap    <= 1'b0;
                cur    <= 0;
                lim    <= 0;
                stp    <= 0;
            end else if (gen_if._start) begin
                active <= 1'b1;
                gap    <= 1'b0;
                cur    <= gen_if.base;
                lim    <= gen_if.limit;
                stp    <= gen_if.step;
            end else if (active) begin
                if (gen_if._valid && gen_if._ready) cur <= cur + stp;
                if (gen_if._done && gen_if._ready) active <= 1'b0;
                gap <= gap_en && ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input int d);
        tr_ready.push_back(o_gready[d]);
        tr_valid.push_back(o_gvalid[d]);
        tr_done.push_back(o_gdone[d]);
        tr_gs.push_back(o_gstart[d]);
    endtask

    task automatic run_call(input int d, input int b, input int l, input int s, input bit hold,
                            input bit busy, output int vcyc, output logic signed [31:0] r0,
                            output logic [31:0] r1, output logic rdone);
        int cyc;
        tr_ready.delete(); tr_valid.delete(); tr_done.delete(); tr_gs.delete();
        h_base = b; h_limit = l; h_step = s;
        h_ready[d] = !hold;
        h_start[d] = 1'b1;
        cyc = 0;
        snap(d);
        while (!o_valid[d] && cyc < 400) begin
            tick();
            cyc++;
            h_start[d] = busy && (cyc == 3 || cyc == 4);
            h_base     = h_start[d] ? b + 100 : b;
            snap(d);
        end
        h_start[d] = 1'b0;
        h_base = b;
        vcyc = cyc; r0 = o_0[d]; r1 = o_1[d]; rdone = o_done[d];
        total++;
        if (!o_valid[d]) $display("FAIL call_timeout lane%0d: no _valid after %0d cycles, required within 400", d, cyc);
        else passed++;
        if (!hold) begin
            tick();
            total++;
            if (o_valid[d] !== 1'b0) $display("FAIL report_exit lane%0d: _valid=%b, required 0", d, o_valid[d]);
            else passed++;
        end
    endtask

    task automatic verify_call(input int d, input int b, input int l, input int s, input int vcyc,
                               input logic signed [31:0] r0, input logic [31:0] r1, input logic rdone,
                               input string tag);
        int exp_sum, exp_cnt, se, n, fd, gs_cnt, gs_first, bad_ready;
        bit pend, exp_r;
        exp_sum = 0; exp_cnt = 0; se = (d == 1) ? 2 : 0;
        n = 0; fd = -1; gs_cnt = 0; gs_first = -1; bad_ready = -1; pend = 1'b0;
        for (int v = b; v < l; v += s) begin
            exp_sum += v;
            exp_cnt++;
        end
        for (int k = 0; k < tr_ready.size(); k++) begin
            if (tr_gs[k]) begin
                gs_cnt++;
                if (gs_first < 0) gs_first = k;
            end
            if (fd < 0) begin
                exp_r = (k >= 2) && !pend;
                if (tr_ready[k] != exp_r && bad_ready < 0) bad_ready = k;
                pend = 1'b0;
                if (tr_valid[k] && tr_ready[k]) begin
                    n++;
                    pend = (se != 0) && (n % se == 0);
                end
                if (tr_done[k] && tr_ready[k]) fd = k;
            end
        end
        total++;
        if (r0 !== exp_sum) $display("FAIL %s sum: got %0d, required %0d", tag, r0, exp_sum);
        else passed++;
        total++;
        if (r1 !== exp_cnt) $display("FAIL %s count: got %0d, required %0d", tag, r1, exp_cnt);
        else passed++;
        total++;
        if (rdone !== 1'b1) $display("FAIL %s done_flag: got %b, required 1", tag, rdone);
        else passed++;
        total++;
        if (gs_cnt != 1 || gs_first != 1)
            $display("FAIL %s gen_start: %0d pulses first at cycle %0d, required 1 pulse at cycle 1", tag, gs_cnt, gs_first);
        else passed++;
        total++;
        if (fd < 0 || vcyc != fd + 1)
            $display("FAIL %s valid_latency: _valid at cycle %0d, final handshake at %0d, required handshake+1", tag, vcyc, fd);
        else passed++;
        total++;
        if (bad_ready >= 0)
            $display("FAIL %s ready_pattern: gen__ready=%b at cycle %0d, required %b", tag, tr_ready[bad_ready], bad_ready, !tr_ready[bad_ready]);
        else passed++;
        total++;
        if (n != exp_cnt) $display("FAIL %s transfers: saw %0d handshakes, required %0d", tag, n, exp_cnt);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({o_valid[d], o_done[d], o_gstart[d], o_gready[d]} !== 4'b0)
                $display("FAIL reset_flags lane%0d: got %b, required 0000", d, {o_valid[d], o_done[d], o_gstart[d], o_gready[d]});
            else passed++;
            total++;
            if (o_0[d] !== 0 || o_1[d] !== 0 || o_gbase[d] !== 0 || o_glimit[d] !== 0 || o_gstep[d] !== 0)
                $display("FAIL reset_values lane%0d: _0=%0d _1=%0d args=%0d/%0d/%0d, required all 0", d, o_0[d], o_1[d], o_gbase[d], o_glimit[d], o_gstep[d]);
            else passed++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int v; logic signed [31:0] r0; logic [31:0] r1; logic rd;
        run_call(0, 1, 11, 3, 1'b0, 1'b0, v, r0, r1, rd);
        verify_call(0, 1, 11, 3, v, r0, r1, rd, "basic");
        total++;
        if (v != 7) $display("FAIL basic_cycle: _valid at cycle %0d, required 7", v);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int v; logic signed [31:0] r0; logic [31:0] r1; logic rd;
        for (int i = 0; i < 2; i++) begin
            run_call(0, 0, 10, 2, 1'b0, 1'b0, v, r0, r1, rd);
            verify_call(0, 0, 10, 2, v, r0, r1, rd, (i == 0) ? "b2b_first" : "b2b_second");
        end
    endtask

    task automatic test_backpressure();
        int v; logic signed [31:0] r0; logic [31:0] r1; logic rd;
        run_call(1, 0, 10, 2, 1'b0, 1'b0, v, r0, r1, rd);
        verify_call(1, 0, 10, 2, v, r0, r1, rd, "stall");
        total++;
        if (tr_ready[4] !== 1'b0 || tr_ready[7] !== 1'b0 || v != 10)
            $display("FAIL stall_cycles: ready@4=%b ready@7=%b valid@%0d, required 0/0/10", tr_ready[4], tr_ready[7], v);
        else passed++;
        run_call(1, 0, 8, 2, 1'b0, 1'b0, v, r0, r1, rd);
        verify_call(1, 0, 8, 2, v, r0, r1, rd, "done_in_stall");
        total++;
        if (tr_done[7] !== 1'b1 || tr_ready[7] !== 1'b0 || v != 9)
            $display("FAIL done_in_stall_cycle: done@7=%b ready@7=%b valid@%0d, required 1/0/9", tr_done[7], tr_ready[7], v);
        else passed++;
    endtask

    task automatic test_empty_busy();
        int v; logic signed [31:0] r0; logic [31:0] r1; logic rd;
        run_call(0, 5, 5, 1, 1'b0, 1'b0, v, r0, r1, rd);
        verify_call(0, 5, 5, 1, v, r0, r1, rd, "empty");
        total++;
        if (v != 3) $display("FAIL empty_cycle: _done at cycle %0d, required 3", v);
        else passed++;
        run_call(0, 3, 13, 2, 1'b0, 1'b1, v, r0, r1, rd);
        verify_call(0, 3, 13, 2, v, r0, r1, rd, "busy_start");
        total++;
        if (o_gbase[0] !== 3) $display("FAIL busy_gen_base: got %0d, required 3", o_gbase[0]);
        else passed++;
    endtask

    task automatic test_host_stall();
        int v; logic signed [31:0] r0; logic [31:0] r1; logic rd;
        run_call(0, 1, 11, 3, 1'b1, 1'b0, v, r0, r1, rd);
        verify_call(0, 1, 11, 3, v, r0, r1, rd, "host_stall");
        for (int i = 1; i < 3; i++) begin
            tick();
            total++;
            if (o_valid[0] !== 1'b1 || o_done[0] !== 1'b1 || o_0[0] !== 22 || o_1[0] !== 4)
                $display("FAIL hold_stable+%0d: valid=%b done=%b _0=%0d _1=%0d, required 1/1/22/4", i, o_valid[0], o_done[0], o_0[0], o_1[0]);
            else passed++;
        end
        h_ready[0] = 1'b1;
        tick();
        total++;
        if (o_valid[0] !== 1'b0 || o_done[0] !== 1'b0 || o_0[0] !== 22)
            $display("FAIL hold_release: valid=%b done=%b _0=%0d, required 0/0/22", o_valid[0], o_done[0], o_0[0]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int v, cyc, n; logic signed [31:0] r0; logic [31:0] r1; logic rd;
        h_base = 2; h_limit = 12; h_step = 2;
        h_ready[0] = 1'b1;
        h_start[0] = 1'b1;
        tick();
        h_start[0] = 1'b0;
        cyc = 0; n = 0;
        while (n < 2 && cyc < 50) begin
            if (o_gvalid[0] && o_gready[0]) n++;
            tick();
            cyc++;
        end
        total++;
        if (n != 2) $display("FAIL mid_transfers: saw %0d, required 2", n);
        else passed++;
        rst = 1'b1;
        tick();
        total++;
        if ({o_valid[0], o_done[0], o_gstart[0], o_gready[0]} !== 4'b0)
            $display("FAIL mid_reset_flags: got %b, required 0000", {o_valid[0], o_done[0], o_gstart[0], o_gready[0]});
        else passed++;
        total++;
        if (o_0[0] !== 0 || o_1[0] !== 0 || o_gbase[0] !== 0 || o_glimit[0] !== 0 || o_gstep[0] !== 0)
            $display("FAIL mid_reset_values: _0=%0d _1=%0d args=%0d/%0d/%0d, required all 0", o_0[0], o_1[0], o_gbase[0], o_glimit[0], o_gstep[0]);
        else passed++;
        rst = 1'b0;
        run_call(0, 1, 11, 3, 1'b0, 1'b0, v, r0, r1, rd);
        verify_call(0, 1, 11, 3, v, r0, r1, rd, "after_reset");
    endtask

    task automatic test_random();
        int v, d, b, l, s; logic signed [31:0] r0; logic [31:0] r1; logic rd;
        for (int i = 0; i < 12; i++) begin
            d = $urandom_range(0, 1);
            b = $urandom_range(0, 40) - 20;
            s = $urandom_range(1, 5);
            l = b + $urandom_range(0, 30);
            gap_en = $urandom_range(0, 1);
            dwl = $urandom_range(0, 1);
            run_call(d, b, l, s, 1'b0, 1'b0, v, r0, r1, rd);
            verify_call(d, b, l, s, v, r0, r1, rd, $sformatf("rand%0d_lane%0d_%0d_%0d_%0d", i, d, b, l, s));
        end
        gap_en = 1'b0;
        dwl = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        h_start = 2'b00;
        h_ready = 2'b11;
        h_base = 0; h_limit = 0; h_step = 0;
        gap_en = 1'b0;
        dwl = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_empty_busy();
        test_host_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
